// File: rtl/mem_pkg.sv
// Shared types and geometry defaults for the memory controller and its I-cache.
package mem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;

  localparam int IDX_W_DEF = $clog2(LINES_DEF);
  localparam int OFF_W_DEF = $clog2(WORDS_DEF);
  localparam int TAG_W_DEF = ADDR_W - IDX_W_DEF - OFF_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FILL = 2'd2
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped I-cache storage: valid bits, tags and line data with an
// instruction lookup port, a tag-probe port for data writes, and fill/invalidate controls.
module icache_array
  import mem_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_hit_o,
  output logic [DATA_W-1:0] i_word_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  output logic              d_hit_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              val_en_i,
  input  logic              inval_en_i,
  input  logic [ADDR_W-1:0] inval_addr_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LOC_W = IDX_W + OFF_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*WORDS];

  logic [IDX_W-1:0] i_idx, d_idx, wr_idx, inv_idx;

  assign i_idx   = i_addr_i[OFF_W +: IDX_W];
  assign d_idx   = d_addr_i[OFF_W +: IDX_W];
  assign wr_idx  = wr_addr_i[OFF_W +: IDX_W];
  assign inv_idx = inval_addr_i[OFF_W +: IDX_W];

  assign i_hit_o  = valid_q[i_idx] && (tag_q[i_idx] == i_addr_i[ADDR_W-1 -: TAG_W]);
  assign d_hit_o  = valid_q[d_idx] && (tag_q[d_idx] == d_addr_i[ADDR_W-1 -: TAG_W]);
  assign i_word_o = data_q[i_addr_i[LOC_W-1:0]];

  // Valid bits are the only state that must reset; stale tags/data are masked by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (inval_en_i) valid_q[inv_idx] <= 1'b0;
      if (val_en_i)   valid_q[wr_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i)  data_q[wr_addr_i[LOC_W-1:0]] <= wr_data_i;
    if (val_en_i) tag_q[wr_idx] <= wr_addr_i[ADDR_W-1 -: TAG_W];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: I-cache fill and uncached data accesses arbitrated onto one
// main-memory port, producing the CPU-wide ready/stall.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | lookup; ready when data done (or none) and fetch hits
//   ST_DATA | single uncached read/write outstanding on main memory
//   ST_FILL | WORDS sequential reads refilling the missing I-cache line
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fetch,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic              mm_ack,
  input  logic [DATA_W-1:0] mm_rdata
);

  localparam int OFF_W = $clog2(WORDS);

  state_e            state_q;
  logic              d_done_q;
  logic [OFF_W-1:0]  cnt_q;
  logic [OFF_W-1:0]  cnt_d;
  logic              mm_req_q;
  logic              mm_we_q;
  logic [ADDR_W-1:0] mm_addr_q;
  logic [DATA_W-1:0] mm_wdata_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              i_hit;
  logic              d_hit;
  logic [DATA_W-1:0] i_word;
  logic              in_idle;
  logic              d_pend;
  logic              fill_start;
  logic              fill_ack;
  logic              fill_last;
  logic              coh_inval;
  logic              inval_en;
  logic [ADDR_W-1:0] inval_addr;

  assign in_idle = (state_q == ST_IDLE);
  assign d_pend  = (re | we) & ~d_done_q;

  // Data goes first: it belongs to the older instruction in the pipeline.
  assign fill_start = in_idle & ~d_pend & i_fetch & ~i_hit;
  assign fill_ack   = (state_q == ST_FILL) & mm_ack;
  assign fill_last  = fill_ack & (cnt_q == OFF_W'(WORDS - 1));
  assign cnt_d      = cnt_q + 1'b1;

  // Self-modifying code: a completed write into a cached line drops that line.
  assign coh_inval  = (state_q == ST_DATA) & mm_ack & mm_we_q & d_hit;
  // Clearing the victim at fill start means an abandoned fill never leaves it valid.
  assign inval_en   = fill_start | coh_inval;
  assign inval_addr = fill_start ? i_addr : mm_addr_q;

  assign ready = rst_n & in_idle & (~(re | we) | d_done_q) & (~i_fetch | i_hit);

  assign instr    = i_hit ? i_word : '0;
  assign rd_data  = rd_data_q;
  assign mm_req   = mm_req_q;
  assign mm_we    = mm_we_q;
  assign mm_addr  = mm_addr_q;
  assign mm_wdata = mm_wdata_q;

  icache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_icache (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_addr_i     (i_addr),
    .i_hit_o      (i_hit),
    .i_word_o     (i_word),
    .d_addr_i     (mm_addr_q),
    .d_hit_o      (d_hit),
    .wr_en_i      (fill_ack),
    .wr_addr_i    (mm_addr_q),
    .wr_data_i    (mm_rdata),
    .val_en_i     (fill_last),
    .inval_en_i   (inval_en),
    .inval_addr_i (inval_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      d_done_q   <= 1'b0;
      cnt_q      <= '0;
      mm_req_q   <= 1'b0;
      mm_we_q    <= 1'b0;
      mm_addr_q  <= '0;
      mm_wdata_q <= '0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ready) d_done_q <= 1'b0;
          if (d_pend) begin
            state_q    <= ST_DATA;
            mm_req_q   <= 1'b1;
            mm_we_q    <= we;
            mm_addr_q  <= d_addr;
            mm_wdata_q <= wrt_data;
          end else if (fill_start) begin
            state_q   <= ST_FILL;
            mm_req_q  <= 1'b1;
            mm_we_q   <= 1'b0;
            mm_addr_q <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt_q     <= '0;
          end
        end
        ST_DATA: begin
          if (mm_ack) begin
            state_q  <= ST_IDLE;
            mm_req_q <= 1'b0;
            mm_we_q  <= 1'b0;
            d_done_q <= 1'b1;
            if (!mm_we_q) rd_data_q <= mm_rdata;
          end
        end
        ST_FILL: begin
          if (mm_ack) begin
            if (fill_last) begin
              state_q  <= ST_IDLE;
              mm_req_q <= 1'b0;
              cnt_q    <= '0;
            end else begin
              cnt_q     <= cnt_d;
              mm_addr_q <= {mm_addr_q[ADDR_W-1:OFF_W], cnt_d};
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          mm_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: main-memory model with fixed latency and a
// queue of expected memory transactions checked as each one is acknowledged.
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int LAT      = 3;
  localparam int WORDS    = 4;
  localparam int DATA_CYC = 1 + LAT;
  localparam int FILL_CYC = 1 + LAT + (WORDS - 1) * (LAT + 1);
  localparam int BUDGET   = 200;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fetch = 1'b0;
  logic [15:0] i_addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] wrt_data = '0;
  logic [15:0] instr;
  logic [15:0] rd_data;
  logic        ready;
  logic        mm_req;
  logic        mm_we;
  logic [15:0] mm_addr;
  logic [15:0] mm_wdata;
  logic        mm_ack = 1'b0;
  logic [15:0] mm_rdata = '0;

  req_t        exp_q[$];
  req_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  int          acks = 0;
  int          lat_cnt = 0;
  logic [15:0] mem_model [0:65535];

  always #5 clk = ~clk;

  mem_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_fetch  (i_fetch),
    .i_addr   (i_addr),
    .re       (re),
    .we       (we),
    .d_addr   (d_addr),
    .wrt_data (wrt_data),
    .instr    (instr),
    .rd_data  (rd_data),
    .ready    (ready),
    .mm_req   (mm_req),
    .mm_we    (mm_we),
    .mm_addr  (mm_addr),
    .mm_wdata (mm_wdata),
    .mm_ack   (mm_ack),
    .mm_rdata (mm_rdata)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // Memory model: acks LAT negedges after a request is seen, one-cycle pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      mm_ack  = 1'b0;
      lat_cnt = 0;
    end else if (mm_ack) begin
      mm_ack  = 1'b0;
      lat_cnt = 0;
      acks++;
    end else if (mm_req) begin
      lat_cnt++;
      if (lat_cnt == LAT) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL mm_unexpected: got addr=%h we=%b, expected no request", mm_addr, mm_we);
        end else begin
          e = exp_q.pop_front();
          if (mm_addr !== e.addr || mm_we !== e.we || (e.we && mm_wdata !== e.wdata)) begin
            miscompares++;
            $display("FAIL mm_txn: got addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                     mm_addr, mm_we, mm_wdata, e.addr, e.we, e.wdata);
          end
        end
        if (mm_we) mem_model[mm_addr] = mm_wdata;
        mm_rdata = mem_model[mm_addr];
        mm_ack   = 1'b1;
      end
    end
  end

  task automatic push_fill(input logic [15:0] a);
    for (int w = 0; w < WORDS; w++)
      exp_q.push_back('{addr: {a[15:2], 2'(w)}, we: 1'b0, wdata: 16'h0000});
  endtask

  task automatic idle_inputs();
    i_fetch = 1'b0; re = 1'b0; we = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk); #2;
  endtask

  // Cycles from the current drive point until ready is seen high; -1 on timeout.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    #1;
    while (ready !== 1'b1) begin
      if (cyc >= BUDGET) begin
        cyc = -1;
        return;
      end
      @(posedge clk); #2;
      cyc++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0", ready); end
    vectors++; if (instr !== 16'h0000) begin miscompares++; $display("FAIL reset_instr: got %h, expected 0000", instr); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data: got %h, expected 0000", rd_data); end
    vectors++; if (mm_req !== 1'b0) begin miscompares++; $display("FAIL reset_mm_req: got %b, expected 0", mm_req); end
    vectors++; if (mm_we !== 1'b0 || mm_addr !== 16'h0000 || mm_wdata !== 16'h0000) begin
      miscompares++; $display("FAIL reset_mm_bus: got we=%b addr=%h wdata=%h, expected all 0", mm_we, mm_addr, mm_wdata);
    end
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_first_fill();
    int cyc;
    push_fill(16'h0000);
    i_fetch = 1'b1; i_addr = 16'h0000;
    wait_ready(cyc);
    vectors++; if (cyc !== FILL_CYC) begin miscompares++; $display("FAIL fill0_cycles: got %0d, expected %0d", cyc, FILL_CYC); end
    vectors++; if (instr !== init_val(16'h0000)) begin miscompares++; $display("FAIL fill0_instr: got %h, expected %h", instr, init_val(16'h0000)); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL fill0_txns: %0d left, expected 0", exp_q.size()); end
    advance();
    i_addr = 16'h0001;
    #1;
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL hit1_ready: got %b, expected 1", ready); end
    vectors++; if (instr !== init_val(16'h0001)) begin miscompares++; $display("FAIL hit1_instr: got %h, expected %h", instr, init_val(16'h0001)); end
    advance();
    idle_inputs();
  endtask

  task automatic test_data_read();
    int cyc;
    exp_q.push_back('{addr: 16'h8000, we: 1'b0, wdata: 16'h0000});
    i_fetch = 1'b1; i_addr = 16'h0002;
    re = 1'b1; d_addr = 16'h8000;
    wait_ready(cyc);
    vectors++; if (cyc !== DATA_CYC) begin miscompares++; $display("FAIL rd_cycles: got %0d, expected %0d", cyc, DATA_CYC); end
    vectors++; if (rd_data !== 16'hBEEF) begin miscompares++; $display("FAIL rd_data: got %h, expected beef", rd_data); end
    vectors++; if (instr !== init_val(16'h0002)) begin miscompares++; $display("FAIL rd_instr: got %h, expected %h", instr, init_val(16'h0002)); end
    advance();
    re = 1'b0; i_addr = 16'h0003;
    advance(); advance();
    vectors++; if (mm_req !== 1'b0 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL rd_extra_req: got mm_req=%b pending=%0d, expected 0/0", mm_req, exp_q.size());
    end
    vectors++; if (rd_data !== 16'hBEEF) begin miscompares++; $display("FAIL rd_hold: got %h, expected beef", rd_data); end
    idle_inputs();
    advance();
  endtask

  task automatic test_write_coherence();
    int cyc;
    exp_q.push_back('{addr: 16'h0002, we: 1'b1, wdata: 16'h1234});
    we = 1'b1; d_addr = 16'h0002; wrt_data = 16'h1234;
    wait_ready(cyc);
    vectors++; if (cyc !== DATA_CYC) begin miscompares++; $display("FAIL wr_cycles: got %0d, expected %0d", cyc, DATA_CYC); end
    advance();
    idle_inputs();
    advance();
    i_fetch = 1'b1; i_addr = 16'h0002;
    #1;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL wr_inval: got ready=%b, expected 0 (line dropped)", ready); end
    push_fill(16'h0002);
    wait_ready(cyc);
    vectors++; if (cyc !== FILL_CYC) begin miscompares++; $display("FAIL refill_cycles: got %0d, expected %0d", cyc, FILL_CYC); end
    vectors++; if (instr !== 16'h1234) begin miscompares++; $display("FAIL refill_instr: got %h, expected 1234", instr); end
    advance();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_q.push_back('{addr: 16'h8001, we: 1'b0, wdata: 16'h0000});
    push_fill(16'h0013);
    re = 1'b1; d_addr = 16'h8001;
    i_fetch = 1'b1; i_addr = 16'h0013;
    wait_ready(cyc);
    vectors++; if (cyc !== DATA_CYC + FILL_CYC) begin miscompares++; $display("FAIL both_cycles: got %0d, expected %0d", cyc, DATA_CYC + FILL_CYC); end
    vectors++; if (rd_data !== init_val(16'h8001)) begin miscompares++; $display("FAIL both_rd_data: got %h, expected %h", rd_data, init_val(16'h8001)); end
    vectors++; if (instr !== init_val(16'h0013)) begin miscompares++; $display("FAIL both_instr: got %h, expected %h", instr, init_val(16'h0013)); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL both_txns: %0d left, expected 0", exp_q.size()); end
    advance();
    idle_inputs();
  endtask

  task automatic test_conflict();
    int cyc;
    i_fetch = 1'b1; i_addr = 16'h0000;
    #1;
    vectors++; if (ready !== 1'b1 || instr !== init_val(16'h0000)) begin
      miscompares++; $display("FAIL conf_hit0: got ready=%b instr=%h, expected 1/%h", ready, instr, init_val(16'h0000));
    end
    advance();
    push_fill(16'h0040);
    i_addr = 16'h0040;
    wait_ready(cyc);
    vectors++; if (cyc !== FILL_CYC || instr !== init_val(16'h0040)) begin
      miscompares++; $display("FAIL conf_fill40: got cyc=%0d instr=%h, expected %0d/%h", cyc, instr, FILL_CYC, init_val(16'h0040));
    end
    advance();
    i_addr = 16'h0000;
    #1;
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL conf_evict: got ready=%b, expected 0", ready); end
    push_fill(16'h0000);
    wait_ready(cyc);
    vectors++; if (cyc !== FILL_CYC || instr !== init_val(16'h0000)) begin
      miscompares++; $display("FAIL conf_refill0: got cyc=%0d instr=%h, expected %0d/%h", cyc, instr, FILL_CYC, init_val(16'h0000));
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    int a0;
    int n;
    push_fill(16'h0081);
    i_fetch = 1'b1; i_addr = 16'h0081;
    a0 = acks;
    n = 0;
    while (acks < a0 + 2 && n < BUDGET) begin
      advance();
      n++;
    end
    vectors++; if (acks < a0 + 2) begin miscompares++; $display("FAIL mid_acks: got %0d acks, expected 2", acks - a0); end
    vectors++; if (mm_req !== 1'b1) begin miscompares++; $display("FAIL mid_req_before: got %b, expected 1", mm_req); end
    rst_n = 1'b0;
    #1;
    vectors++; if (mm_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_drop: got %b, expected 0", mm_req); end
    exp_q.delete();
    advance(); advance();
    rst_n = 1'b1;
    push_fill(16'h0081);
    wait_ready(cyc);
    vectors++; if (cyc !== FILL_CYC) begin miscompares++; $display("FAIL mid_refill_cycles: got %0d, expected %0d", cyc, FILL_CYC); end
    vectors++; if (instr !== init_val(16'h0081)) begin miscompares++; $display("FAIL mid_refill_instr: got %h, expected %h", instr, init_val(16'h0081)); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mid_txns: %0d left, expected 0", exp_q.size()); end
    advance();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem_model[i] = init_val(i[15:0]);
    mem_model[16'h8000] = 16'hBEEF;
    test_reset();
    test_first_fill();
    test_data_read();
    test_write_coherence();
    test_back_to_back();
    test_conflict();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the pipelined CPU's instruction-fetch/data ports and a single word-wide, variable-latency main memory. Contains a 16-line direct-mapped instruction cache (4 words/line) and an uncached data path. Arbitrates both onto one main-memory port and produces the CPU-wide `ready` that freezes every pipeline register while an access is outstanding.

## Interface
- `LINES`, 16, cache lines (power of two)
- `WORDS`, 4, 16-bit words per line (power of two)
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `i_fetch`  in  1  instruction fetch requested this cycle
- `i_addr`  in  16  word address of fetch (PC)
- `re`  in  1  data read request
- `we`  in  1  data write request (never together with `re`)
- `d_addr`  in  16  data word address
- `wrt_data`  in  16  data write value
- `instr`  out  16  fetched instruction; valid when `ready` & `i_fetch`
- `rd_data`  out  16  data read value; valid when `ready` & `re`
- `ready`  out  1  all requested accesses complete this cycle; CPU advances only when high
- `mm_req`  out  1  main-memory request, held until `mm_ack`
- `mm_we`  out  1  request is a write
- `mm_addr`  out  16  word address
- `mm_wdata`  out  16  write data
- `mm_ack`  in  1  one-cycle completion pulse; `mm_rdata` valid with it on reads
- `mm_rdata`  in  16  read data

## Operation
- Address split (defaults): tag `[15:6]`, index `[5:2]`, offset `[1:0]`.
- I-hit: valid[index] & tag match; `instr` = combinational read of line word. On miss `instr` = 16'h0000.
- States: IDLE, DATA, FILL.
- IDLE: if (`re`|`we`) & ~`d_done` -> DATA (data first: it belongs to an older instruction). Else if `i_fetch` & ~hit -> FILL. Else stay.
- DATA: `mm_req`=1, `mm_we`=`we`, `mm_addr`=`d_addr`, `mm_wdata`=`wrt_data`. On `mm_ack`: latch `mm_rdata` into `rd_data` (reads only), set `d_done`, -> IDLE.
- FILL: issue WORDS sequential reads at {tag,index,word counter} starting at 0; each `mm_ack` writes the word, increments counter. On last ack: set valid, write tag, counter -> 0, -> IDLE.
- `ready` = IDLE & (~(`re`|`we`) | `d_done`) & (~`i_fetch` | hit). `d_done` clears on any cycle with `ready`=1.
- Write coherence: a completed data write whose address hits a valid I-cache line clears that line's valid bit (self-modifying code refetches).
- `mm_req` deasserts in the cycle after final `mm_ack`; back-to-back FILL words may re-request immediately (`mm_req` stays high across words).

## Timing
- Reset values: `ready`=0 while `rst_n` low, `instr`=0, `rd_data`=0, `mm_req`=0, `mm_we`=0, `mm_addr`=0, `mm_wdata`=0; all valid bits 0, state IDLE, `d_done`=0, counter 0.
- I-hit, no data access: `ready`=1 same cycle, zero wait.
- I-miss: `ready` low for fill (WORDS acks) + 1 cycle re-lookup in IDLE.
- Data access: `ready` low until cycle after `mm_ack`; `rd_data` stable from that cycle until next data read completes.
- Data access + I-miss together: DATA, then FILL (`d_done` held), then `ready`.
- `mm_ack` outside DATA/FILL is ignored.
- Reset mid-operation: immediate abort, `mm_req` drops asynchronously; main memory must tolerate an abandoned request. No partial line left valid.
- Fill never marks a line valid early; a reset or abort mid-fill leaves valid=0.

## Structure
- Package `mem_pkg`: state enum (IDLE/DATA/FILL), `LINES`/`WORDS` defaults, derived index/offset/tag widths.
- Sub-module `icache_array`: valid bits, tag store, data store; combinational lookup port, synchronous word write, line validate, line invalidate, async valid clear on reset. FSM, arbitration and `ready` stay in `mem_ctrl`.

## Test plan
- Reset, `i_fetch`=1 @0x0000, mem latency 3 -> 4 reads 0x0000–0x0003, `ready` first high after last ack +1, `instr`=mem[0]; next fetch 0x0001 ready same cycle.
- `re`=1 @0x8000 (mem=0xBEEF) with I-hit -> one mm read, `ready` high one cycle after ack, `rd_data`=0xBEEF, no extra request.
- `we`=1 @0x0002 data 0x1234 after line 0 cached -> mm write, line 0 invalidated; fetch 0x0002 misses, refill returns 0x1234.
- Simultaneous `re` and I-miss -> data read issued first, then fill; single `ready` pulse after both, both outputs correct.
- Conflict: fetch 0x0000 then 0x0040 (same index) -> second evicts first; refetch 0x0000 misses again.
- Assert `rst_n` low mid-fill (after 2 acks) -> `mm_req`=0 immediately; after release, fetch of same address performs full 4-word fill.
